qspi_stream_arbiter: RTL and testbench
======================================

// Module: qspi_stream_arbiter
// PURPOSE
// Shares the single QSPI flash read device between two streaming requesters:
// port 0 is the flash page buffer and port 1 is a direct/DMA read port.
// Keeps a resumable word pointer per port and grants the device round-robin.
// Long streams are preempted after MAX_BURST words, and the preempted port
// later resumes at its saved address. Sits between the requesters and the
// QSPI device.
// PARAMETERS
// MAX_BURST  128  words an owner may stream before yielding, if the other port waits (>=1)
// PORTS
// clk                 in   1   clock
// rst                 in   1   synchronous, active-high reset
// enable              in   1   arbiter enable; low forces IDLE
// rN_start (N=0,1)    in   1   pulse: load new stream address from rN_address
// rN_address          in   24  byte address; bits [1:0] ignored
// rN_req              in   1   level: port wants words
// rN_grant            out  1   port currently owns device (CHANGE/STREAM/DRAIN)
// rN_dataValid        out  1   qspi_readData is a word for this port this cycle
// rN_pointer          out  24  address of port's next word
// readData            out  32  = qspi_readData (shared)
// qspi_address        out  24  = owner pointer
// qspi_changeAddress  out  1   1-cycle pulse to reposition device
// qspi_requestData    out  1   level request for words
// qspi_readData       in   32  device word
// qspi_readDataValid  in   1   device word valid
// qspi_initialised    in   1   device ready
// qspi_busy           in   1   device mid-transfer
// BEHAVIOUR
// Reset: state IDLE; owner=0; lastOwner=1 (port 0 served first); ptr0=ptr1=0;
//   restart flags 0. All outputs 0, except readData and rN_pointer, which follow
//   their sources.
// Pointer:
//   - rN_start loads ptrN <= {rN_address[23:2],2'b00} in any state.
//   - ptrN += 4 per word accepted for port N; wraps 0xFFFFFC -> 0x000000.
// Arbitration in IDLE, when enable && qspi_initialised:
//   - Candidates are ports with rN_req=1.
//   - If both request, pick !lastOwner. Go to CHANGE and set rN_grant=1 from the next cycle.
//   - If rN_start coincides with the pick, CHANGE uses the new ptrN (registered).
// CHANGE:
//   - While qspi_busy, wait.
//   - Otherwise qspi_changeAddress=1 for exactly 1 cycle with qspi_address=ptr[owner].
//   - Next state is STREAM.
// STREAM:
//   - qspi_requestData=1.
//   - On qspi_readDataValid: r<owner>_dataValid=1 the same cycle (combinational),
//     ptr[owner]+=4, wordCount++.
//   - Exit to DRAIN on any of:
//     - owner req=0;
//     - other req=1 && wordCount reaches MAX_BURST (count includes this cycle's word);
//     - owner start=1, which sets restart[owner].
//   - wordCount clears on entering CHANGE.
// DRAIN:
//   - qspi_requestData=0.
//   - Late valid words:
//     - restart[owner]=1: discarded (no dataValid, ptr unchanged);
//     - otherwise: forwarded and ptr advanced.
//   - When !qspi_busy && !qspi_readDataValid: lastOwner<=owner, clear restart[owner], go to IDLE.
//   - A restarted owner competes again through normal arbitration.
// Abort: enable=0 or qspi_initialised=0 in any state.
//   - Go to IDLE next cycle; qspi_requestData and grants deassert that cycle.
//   - Words in that cycle are discarded; pointers are retained.
//   - On re-enable the port resumes at its ptr.
// Invariants:
//   - At most one rN_grant is high, and rN_dataValid implies rN_grant.
//   - qspi_changeAddress is never asserted with qspi_busy=1.
//   - Pointer writes: start has priority over a same-cycle word.
// TESTING
// 1 r0_start 0x000100 + r0_req; device not busy -> changeAddress pulse with qspi_address=0x000100;
//   3 words give r0_dataValid x3, r0_pointer=0x00010C.
// 2 MAX_BURST=4; r0 streaming from 0x000000, r1_start 0x002000 + r1_req -> r0 gets 4 words then DRAIN;
//   r1 changeAddress 0x002000; after r1 yields, r0 resumes with qspi_address=0x000010.
// 3 r0_start 0x000800 mid-stream, with a late word in DRAIN -> word dropped, r0_pointer stays 0x000800;
//   next changeAddress carries 0x000800.
// 4 enable=0 mid-stream -> requestData=0 and grant=0 next cycle; re-enable -> resume at saved pointer.
// 5 r1_start 0x000103 -> qspi_address=0x000100; r0_start 0xFFFFFC, 1 word -> r0_pointer=0x000000.
// 6 Both ports stream long bursts -> grants alternate; no cycle with both grants or with changeAddress && busy.

Source files
------------

// File: rtl/qspi_stream_arbiter.sv
// Round-robin sharing of one QSPI read device between two streaming requesters,
// with a resumable word pointer per port and preemption after MAX_BURST words.
module qspi_stream_arbiter #(
  parameter int unsigned MAX_BURST = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        r0_start,
  input  logic [23:0] r0_address,
  input  logic        r0_req,
  output logic        r0_grant,
  output logic        r0_dataValid,
  output logic [23:0] r0_pointer,
  input  logic        r1_start,
  input  logic [23:0] r1_address,
  input  logic        r1_req,
  output logic        r1_grant,
  output logic        r1_dataValid,
  output logic [23:0] r1_pointer,
  output logic [31:0] readData,
  output logic [23:0] qspi_address,
  output logic        qspi_changeAddress,
  output logic        qspi_requestData,
  input  logic [31:0] qspi_readData,
  input  logic        qspi_readDataValid,
  input  logic        qspi_initialised,
  input  logic        qspi_busy
);
  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, CHANGE, STREAM, DRAIN} state_t;

  state_t        state;
  logic          owner;
  logic          last_owner;
  logic [23:0]   ptr0;
  logic [23:0]   ptr1;
  logic [1:0]    restart;
  logic [1:0]    grant;
  logic [CW-1:0] word_count;
  logic [CW:0]   count_inc;
  logic          run;
  logic          own_req;
  logic          other_req;
  logic          own_start;
  logic          word_ok;
  logic          burst_done;
  logic          stream_exit;
  logic          pick;

  always_comb begin
    run         = enable && qspi_initialised;
    own_req     = owner ? r1_req : r0_req;
    other_req   = owner ? r0_req : r1_req;
    own_start   = owner ? r1_start : r0_start;
    // Late words after a restart belong to the abandoned stream and are dropped.
    word_ok     = run && qspi_readDataValid &&
                  ((state == STREAM) || ((state == DRAIN) && !restart[owner]));
    count_inc   = {1'b0, word_count} + {{CW{1'b0}}, word_ok};
    burst_done  = count_inc >= (CW + 1)'(MAX_BURST);
    stream_exit = !own_req || (other_req && burst_done) || own_start;
    pick        = (r0_req && r1_req) ? !last_owner : r1_req;
  end

  assign r0_dataValid       = word_ok && !owner;
  assign r1_dataValid       = word_ok && owner;
  assign r0_grant           = grant[0];
  assign r1_grant           = grant[1];
  assign r0_pointer         = ptr0;
  assign r1_pointer         = ptr1;
  assign readData           = qspi_readData;
  assign qspi_address       = owner ? ptr1 : ptr0;
  // Combinational so the pulse can never coincide with a busy device.
  assign qspi_changeAddress = run && (state == CHANGE) && !qspi_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr0 <= '0;
      ptr1 <= '0;
    end else begin
      if (r0_start)          ptr0 <= r0_address & 24'hFFFFFC;
      else if (r0_dataValid) ptr0 <= ptr0 + 24'd4;
      if (r1_start)          ptr1 <= r1_address & 24'hFFFFFC;
      else if (r1_dataValid) ptr1 <= ptr1 + 24'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      owner            <= 1'b0;
      last_owner       <= 1'b1;
      restart          <= '0;
      word_count       <= '0;
      grant            <= '0;
      qspi_requestData <= 1'b0;
    end else if (!run) begin
      state            <= IDLE;
      grant            <= '0;
      restart          <= '0;
      qspi_requestData <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (r0_req || r1_req) begin
            owner      <= pick;
            grant      <= pick ? 2'b10 : 2'b01;
            word_count <= '0;
            state      <= CHANGE;
          end
        end
        CHANGE: begin
          if (!qspi_busy) begin
            state            <= STREAM;
            qspi_requestData <= 1'b1;
          end
        end
        STREAM: begin
          word_count <= burst_done ? CW'(MAX_BURST) : count_inc[CW-1:0];
          if (stream_exit) begin
            state            <= DRAIN;
            qspi_requestData <= 1'b0;
            if (own_start) restart[owner] <= 1'b1;
          end
        end
        DRAIN: begin
          if (!qspi_busy && !qspi_readDataValid) begin
            state          <= IDLE;
            last_owner     <= owner;
            restart[owner] <= 1'b0;
            grant          <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_qspi_stream_arbiter.sv
// Bench for qspi_stream_arbiter: directed scenarios plus a randomized two-port
// stream checked against a per-port expected-pointer model and a word-address device.
module tb_qspi_stream_arbiter;
  localparam int unsigned MB = 4;

  logic        clk = 1'b0;
  logic        rst, enable;
  logic        r0_start, r0_req, r1_start, r1_req;
  logic [23:0] r0_address, r1_address;
  logic        r0_grant, r0_dataValid, r1_grant, r1_dataValid;
  logic [23:0] r0_pointer, r1_pointer, qspi_address;
  logic [31:0] readData, qspi_readData;
  logic        qspi_changeAddress, qspi_requestData;
  logic        qspi_readDataValid, qspi_initialised, qspi_busy;

  int checks = 0;
  int errors = 0;

  // Device model: every word carries its own byte address in the low 24 bits.
  logic [23:0] dev_addr = '0;
  bit          busy = 1'b0;

  logic        s_cad, s_g0, s_g1, s_dv0, s_dv1, s_rq;
  logic [23:0] s_addr, s_p0, s_p1;
  logic [31:0] s_rd;

  qspi_stream_arbiter #(.MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .r0_start(r0_start), .r0_address(r0_address), .r0_req(r0_req),
    .r0_grant(r0_grant), .r0_dataValid(r0_dataValid), .r0_pointer(r0_pointer),
    .r1_start(r1_start), .r1_address(r1_address), .r1_req(r1_req),
    .r1_grant(r1_grant), .r1_dataValid(r1_dataValid), .r1_pointer(r1_pointer),
    .readData(readData), .qspi_address(qspi_address),
    .qspi_changeAddress(qspi_changeAddress), .qspi_requestData(qspi_requestData),
    .qspi_readData(qspi_readData), .qspi_readDataValid(qspi_readDataValid),
    .qspi_initialised(qspi_initialised), .qspi_busy(qspi_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock cycle: drive device outputs at the falling edge, sample the DUT,
  // then let the device follow the reposition/word handshake at the rising edge.
  task automatic tick(input bit v);
    qspi_readDataValid = v;
    qspi_readData      = {8'h5A, dev_addr};
    qspi_busy          = busy;
    #1;
    s_cad = qspi_changeAddress; s_addr = qspi_address;
    s_g0  = r0_grant;   s_g1  = r1_grant;
    s_dv0 = r0_dataValid; s_dv1 = r1_dataValid;
    s_rq  = qspi_requestData; s_rd = readData;
    s_p0  = r0_pointer; s_p1  = r1_pointer;
    @(posedge clk);
    if (s_cad) dev_addr = s_addr;
    else if (v) dev_addr = dev_addr + 24'd4;
    @(negedge clk);
    r0_start = 1'b0;
    r1_start = 1'b0;
  endtask

  task automatic run_until_cad(input int unsigned limit, output bit seen);
    seen = 1'b0;
    for (int unsigned i = 0; i < limit && !seen; i++) begin
      tick(1'b0);
      seen = s_cad;
    end
  endtask

  task automatic run_until_free(input int unsigned limit, output bit seen);
    seen = 1'b0;
    for (int unsigned i = 0; i < limit && !seen; i++) begin
      tick(1'b0);
      seen = !s_g0 && !s_g1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; qspi_initialised = 1'b1;
    r0_start = 1'b0; r1_start = 1'b0; r0_req = 1'b0; r1_req = 1'b0;
    r0_address = 24'h123456; r1_address = 24'h654321;
    tick(1'b0);
    tick(1'b0);
    checks++; if ({s_g0, s_g1, s_dv0, s_dv1, s_rq, s_cad} !== 6'b0) begin errors++;
      $display("FAIL reset_outputs: got %b want 000000", {s_g0, s_g1, s_dv0, s_dv1, s_rq, s_cad}); end
    checks++; if (s_p0 !== 24'h0 || s_p1 !== 24'h0 || s_addr !== 24'h0) begin errors++;
      $display("FAIL reset_pointers: got p0=%h p1=%h addr=%h want 0", s_p0, s_p1, s_addr); end
    checks++; if (s_rd !== 32'h5A000000) begin errors++;
      $display("FAIL reset_readData: got %h want 5a000000", s_rd); end
    rst = 1'b0;
  endtask

  task automatic test_single_stream();
    bit ok;
    r0_address = 24'h000100; r0_start = 1'b1; r0_req = 1'b1;
    tick(1'b0);
    tick(1'b0);
    checks++; if (s_cad !== 1'b1 || s_addr !== 24'h000100 || s_g0 !== 1'b1) begin errors++;
      $display("FAIL single_change: got cad=%b addr=%h g0=%b want 1 000100 1", s_cad, s_addr, s_g0); end
    for (int unsigned i = 0; i < 3; i++) begin
      tick(1'b1);
      checks++; if (s_dv0 !== 1'b1 || s_rd[23:0] !== 24'h000100 + 24'(4 * i)) begin errors++;
        $display("FAIL single_word%0d: got dv=%b data=%h want 1 %h", i, s_dv0, s_rd[23:0], 24'h000100 + 24'(4 * i)); end
    end
    r0_req = 1'b0;
    tick(1'b0);
    checks++; if (s_p0 !== 24'h00010C) begin errors++;
      $display("FAIL single_pointer: got %h want 00010c", s_p0); end
    run_until_free(10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_release: got grant held want released"); end
  endtask

  task automatic test_preempt();
    bit ok;
    int unsigned n0, n1;
    r0_address = 24'h000000; r0_start = 1'b1; r0_req = 1'b1;
    run_until_cad(10, ok);
    checks++; if (!ok || s_addr !== 24'h000000) begin errors++;
      $display("FAIL preempt_r0_change: got seen=%b addr=%h want 1 000000", ok, s_addr); end
    r1_address = 24'h002000; r1_start = 1'b1; r1_req = 1'b1;
    n0 = 0; ok = 1'b0;
    for (int unsigned i = 0; i < 40 && !ok; i++) begin
      tick(qspi_requestData);
      if (s_dv0) n0++;
      ok = s_cad;
    end
    checks++; if (!ok || n0 != MB) begin errors++;
      $display("FAIL preempt_burst: got seen=%b words=%0d want 1 %0d", ok, n0, MB); end
    checks++; if (s_g1 !== 1'b1 || s_g0 !== 1'b0 || s_addr !== 24'h002000) begin errors++;
      $display("FAIL preempt_r1_change: got g1=%b g0=%b addr=%h want 1 0 002000", s_g1, s_g0, s_addr); end
    n1 = 0; ok = 1'b0;
    for (int unsigned i = 0; i < 40 && !ok; i++) begin
      tick(qspi_requestData);
      if (s_dv1) n1++;
      if (n1 == 2) r1_req = 1'b0;
      ok = s_cad;
    end
    checks++; if (s_p1 !== 24'h00200C) begin errors++;
      $display("FAIL preempt_r1_pointer: got %h want 00200c", s_p1); end
    checks++; if (!ok || s_g0 !== 1'b1 || s_addr !== 24'h000010) begin errors++;
      $display("FAIL preempt_resume: got seen=%b g0=%b addr=%h want 1 1 000010", ok, s_g0, s_addr); end
  endtask

  task automatic test_restart();
    bit ok;
    tick(1'b1);
    tick(1'b1);
    checks++; if (s_dv0 !== 1'b1 || s_rd[23:0] !== 24'h000014) begin errors++;
      $display("FAIL restart_stream: got dv=%b data=%h want 1 000014", s_dv0, s_rd[23:0]); end
    r0_address = 24'h000800; r0_start = 1'b1;
    tick(1'b0);
    tick(1'b1);
    checks++; if (s_dv0 !== 1'b0 || s_p0 !== 24'h000800) begin errors++;
      $display("FAIL restart_late_drop: got dv=%b p0=%h want 0 000800", s_dv0, s_p0); end
    tick(1'b0);
    checks++; if (s_p0 !== 24'h000800) begin errors++;
      $display("FAIL restart_pointer: got %h want 000800", s_p0); end
    run_until_cad(10, ok);
    checks++; if (!ok || s_addr !== 24'h000800 || s_g0 !== 1'b1) begin errors++;
      $display("FAIL restart_change: got seen=%b addr=%h g0=%b want 1 000800 1", ok, s_addr, s_g0); end
  endtask

  task automatic test_abort();
    bit ok;
    tick(1'b1);
    tick(1'b1);
    enable = 1'b0;
    tick(1'b1);
    checks++; if (s_dv0 !== 1'b0) begin errors++;
      $display("FAIL abort_word_drop: got dv=%b want 0", s_dv0); end
    tick(1'b0);
    checks++; if (s_rq !== 1'b0 || s_g0 !== 1'b0 || s_p0 !== 24'h000808) begin errors++;
      $display("FAIL abort_release: got rq=%b g0=%b p0=%h want 0 0 000808", s_rq, s_g0, s_p0); end
    enable = 1'b1;
    run_until_cad(10, ok);
    checks++; if (!ok || s_addr !== 24'h000808 || s_g0 !== 1'b1) begin errors++;
      $display("FAIL abort_resume: got seen=%b addr=%h g0=%b want 1 000808 1", ok, s_addr, s_g0); end
  endtask

  task automatic test_align_wrap();
    bit ok;
    r0_req = 1'b0;
    run_until_free(10, ok);
    r1_address = 24'h000103; r1_start = 1'b1; r1_req = 1'b1;
    run_until_cad(10, ok);
    checks++; if (!ok || s_addr !== 24'h000100 || s_g1 !== 1'b1) begin errors++;
      $display("FAIL align_change: got seen=%b addr=%h g1=%b want 1 000100 1", ok, s_addr, s_g1); end
    r1_req = 1'b0;
    run_until_free(10, ok);
    r0_address = 24'hFFFFFC; r0_start = 1'b1; r0_req = 1'b1;
    run_until_cad(10, ok);
    checks++; if (!ok || s_addr !== 24'hFFFFFC) begin errors++;
      $display("FAIL wrap_change: got seen=%b addr=%h want 1 fffffc", ok, s_addr); end
    tick(1'b1);
    checks++; if (s_dv0 !== 1'b1 || s_rd[23:0] !== 24'hFFFFFC) begin errors++;
      $display("FAIL wrap_word: got dv=%b data=%h want 1 fffffc", s_dv0, s_rd[23:0]); end
    r0_req = 1'b0;
    tick(1'b0);
    checks++; if (s_p0 !== 24'h000000) begin errors++;
      $display("FAIL wrap_pointer: got %h want 000000", s_p0); end
    run_until_free(10, ok);
  endtask

  task automatic test_random_streams();
    logic [23:0] exp_ptr [2];
    logic [23:0] a0, a1;
    bit st0, st1, v, prev_rq, ok;
    int cur, prev_cur, last_ten;
    int unsigned tenures;
    a0 = 24'($urandom()) & 24'hFFFFFC; a1 = 24'($urandom()) & 24'hFFFFFC;
    r0_address = a0; r1_address = a1; r0_start = 1'b1; r1_start = 1'b1;
    tick(1'b0);
    exp_ptr[0] = a0; exp_ptr[1] = a1;
    r0_req = 1'b1; r1_req = 1'b1;
    prev_rq = 1'b0; prev_cur = -1; last_ten = -1; tenures = 0;
    for (int unsigned cyc = 0; cyc < 1500; cyc++) begin
      st0 = ($urandom_range(0, 39) == 0) && (!r0_grant || qspi_requestData);
      st1 = ($urandom_range(0, 39) == 0) && (!r1_grant || qspi_requestData);
      a0 = 24'($urandom()); a1 = 24'($urandom());
      r0_start = st0; r0_address = a0; r1_start = st1; r1_address = a1;
      v = (qspi_requestData || prev_rq) && ($urandom_range(0, 2) != 0);
      prev_rq = qspi_requestData;
      busy = ($urandom_range(0, 3) == 0);
      tick(v);
      checks++; if (s_g0 && s_g1) begin errors++;
        $display("FAIL rand_one_grant cyc %0d: got both grants want at most one", cyc); end
      checks++; if (s_cad && busy) begin errors++;
        $display("FAIL rand_change_busy cyc %0d: got changeAddress with busy want none", cyc); end
      checks++; if ((s_dv0 && !s_g0) || (s_dv1 && !s_g1)) begin errors++;
        $display("FAIL rand_valid_grant cyc %0d: got dv=%b%b g=%b%b", cyc, s_dv1, s_dv0, s_g1, s_g0); end
      checks++; if (s_p0 !== exp_ptr[0] || s_p1 !== exp_ptr[1]) begin errors++;
        $display("FAIL rand_pointer cyc %0d: got %h %h want %h %h", cyc, s_p0, s_p1, exp_ptr[0], exp_ptr[1]); end
      if (s_cad) begin
        checks++; if (s_addr !== exp_ptr[s_g1 ? 1 : 0]) begin errors++;
          $display("FAIL rand_change_addr cyc %0d: got %h want %h", cyc, s_addr, exp_ptr[s_g1 ? 1 : 0]); end
      end
      if (s_dv0 || s_dv1) begin
        checks++; if (s_rd[23:0] !== exp_ptr[s_dv1 ? 1 : 0]) begin errors++;
          $display("FAIL rand_word cyc %0d: got %h want %h", cyc, s_rd[23:0], exp_ptr[s_dv1 ? 1 : 0]); end
      end
      cur = s_g0 ? 0 : (s_g1 ? 1 : -1);
      if (cur >= 0 && prev_cur < 0) begin
        if (last_ten >= 0) begin
          checks++; if (cur == last_ten) begin errors++;
            $display("FAIL rand_alternate cyc %0d: got port %0d again want port %0d", cyc, cur, 1 - cur); end
        end
        last_ten = cur;
        tenures++;
      end
      prev_cur = cur;
      if (st0) exp_ptr[0] = a0 & 24'hFFFFFC; else if (s_dv0) exp_ptr[0] = exp_ptr[0] + 24'd4;
      if (st1) exp_ptr[1] = a1 & 24'hFFFFFC; else if (s_dv1) exp_ptr[1] = exp_ptr[1] + 24'd4;
    end
    checks++; if (tenures < 20) begin errors++;
      $display("FAIL rand_progress: got %0d grant tenures want at least 20", tenures); end
    r0_req = 1'b0; r1_req = 1'b0; busy = 1'b0;
    run_until_free(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rand_release: got grant held want released"); end
  endtask

  initial begin
    test_reset();
    test_single_stream();
    test_preempt();
    test_restart();
    test_abort();
    test_align_wrap();
    test_random_streams();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
